reset_sequencer: RTL and testbench

- Parametrised successor to the SoC top-level auto-reset counter; one instance per board top.
- Waits for PLL lock, then holds reset for a programmable time.
- Releases N reset outputs in staged order, e.g. SDRAM controller, then CPU, then peripherals.
- Re-asserts all outputs on lock loss or on a debounced button+key-selector combination, and records the reset cause.

---
 rtl/reset_seq_pkg.sv | 19 +
 rtl/btn_debounce.sv | 42 ++++
 rtl/reset_sequencer.sv | 135 +++++++++++++
 tb/tb_reset_sequencer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types for the staged reset sequencer: FSM states and reset-cause codes.
// Both enums encode their power-on value as zero.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR  = 2'd0,
        CAUSE_EXT  = 2'd1,
        CAUSE_LOCK = 2'd2,
        CAUSE_BTN  = 2'd3
    } cause_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stable-time debouncer for a raw push-button.
// The debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset_i,
    input  logic in_i,
    output logic out_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             in_meta;
    logic             in_s;
    logic             db_q;
    logic [CNT_W-1:0] cnt;

    // Synchroniser flops carry no reset so they always track the pin.
    always_ff @(posedge clk) begin
        in_meta <= in_i;
        in_s    <= in_meta;
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            db_q <= 1'b0;
            cnt  <= '0;
        end else if (in_s == db_q) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            db_q <= in_s;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign out_o = db_q;

endmodule

// File: rtl/reset_sequencer.sv
// Board-level reset sequencer: waits for PLL lock, holds, then releases N_OUT resets in order.
// Re-asserts everything on external reset, lock loss or an armed button, and records why.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_OUT           = 3,
    parameter int HOLD_CYCLES     = 31,
    parameter int STAGE_CYCLES    = 16,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int KEY_W           = 4,
    parameter int KEY_MATCH       = 1
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             pll_locked_i,
    input  logic             btn_i,
    input  logic [KEY_W-1:0] key_i,
    output logic [N_OUT-1:0] reset_o,
    output logic             ready_o,
    output logic [1:0]       cause_o
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int STG_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [N_OUT-1:0] REL_FIRST  = N_OUT'(1);
    localparam logic [KEY_W-1:0] KEY_ARM    = KEY_W'(KEY_MATCH);

    logic             lock_meta;
    logic             locked_s;
    logic [KEY_W-1:0] key_meta;
    logic [KEY_W-1:0] key_s;
    logic             btn_db;
    logic             btn_hold;

    state_t           state;
    cause_t           cause_q;
    logic [CNT_W-1:0] cnt;
    logic [STG_W-1:0] stg;
    logic [N_OUT-1:0] rel_q;
    logic             ready_q;
    logic             last_stage;

    always_ff @(posedge clk) begin
        lock_meta <= pll_locked_i;
        locked_s  <= lock_meta;
        key_meta  <= key_i;
        key_s     <= key_meta;
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .reset_i(reset_i),
        .in_i   (btn_i),
        .out_o  (btn_db)
    );

    assign btn_hold   = btn_db && (key_s == KEY_ARM);
    assign last_stage = (int'(stg) + 2 == N_OUT);

    // rel_q holds released bits (1 = deasserted) so the all-zero power-on state
    // means every reset asserted, state WAIT_LOCK and cause POR.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state   <= WAIT_LOCK;
            rel_q   <= '0;
            ready_q <= 1'b0;
            cnt     <= '0;
            stg     <= '0;
            cause_q <= CAUSE_EXT;
        end else if (state != WAIT_LOCK && !locked_s) begin
            state   <= WAIT_LOCK;
            rel_q   <= '0;
            ready_q <= 1'b0;
            cnt     <= '0;
            stg     <= '0;
            cause_q <= CAUSE_LOCK;
        end else if ((state == RELEASE || state == RUN) && btn_hold) begin
            state   <= HOLD;
            rel_q   <= '0;
            ready_q <= 1'b0;
            cnt     <= '0;
            stg     <= '0;
            cause_q <= CAUSE_BTN;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end
                end
                HOLD: begin
                    if (btn_hold) begin
                        cnt <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        cnt     <= '0;
                        stg     <= '0;
                        rel_q   <= REL_FIRST;
                        state   <= (N_OUT == 1) ? RUN : RELEASE;
                        ready_q <= (N_OUT == 1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt == STAGE_LAST) begin
                        cnt   <= '0;
                        stg   <= stg + STG_W'(1);
                        rel_q <= (rel_q << 1) | REL_FIRST;
                        if (last_stage) begin
                            state   <= RUN;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                end
                default: state <= WAIT_LOCK;
            endcase
        end
    end

    assign reset_o = ~rel_q;
    assign ready_o = ready_q;
    assign cause_o = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: staged release timing, lock loss, button re-assert,
// ignored button cases, external reset priority, with a continuous thermometer check.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic       pll_locked_i = 1'b0;
    logic       btn_i = 1'b0;
    logic [3:0] key_i = 4'd0;
    logic [2:0] reset_o;
    logic       ready_o;
    logic [1:0] cause_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    reset_sequencer #(
        .N_OUT(3),
        .HOLD_CYCLES(31),
        .STAGE_CYCLES(4),
        .DEBOUNCE_CYCLES(8),
        .KEY_W(4),
        .KEY_MATCH(1)
    ) dut (
        .clk         (clk),
        .reset_i     (reset_i),
        .pll_locked_i(pll_locked_i),
        .btn_i       (btn_i),
        .key_i       (key_i),
        .reset_o     (reset_o),
        .ready_o     (ready_o),
        .cause_o     (cause_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic to_edge(input int e);
        while (cyc < e) step();
    endtask

    task automatic check_out(input string tag, input logic [2:0] rst, input logic rdy,
                             input logic [1:0] cause);
        check({tag, ".reset_o"}, {5'd0, reset_o}, {5'd0, rst});
        check({tag, ".ready_o"}, {7'd0, ready_o}, {7'd0, rdy});
        check({tag, ".cause_o"}, {6'd0, cause_o}, {6'd0, cause});
    endtask

    // Thermometer and ready consistency on every falling edge once outputs are defined.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            checks++;
            assert ((((reset_o << 1) & ~reset_o) & 3'b111) == 3'b000 &&
                    ready_o === (reset_o == 3'b000)) else begin
                errors++;
                $error("FAIL thermometer observed=%b/%b expected monotone with ready", reset_o, ready_o);
            end
        end
    end

    initial begin
        // Power-up, lock at edge 10, HOLD entered on edge 12
        to_edge(1);
        check_out("por", 3'b111, 1'b0, 2'd0);
        to_edge(9);
        pll_locked_i = 1'b1;
        to_edge(42); check_out("hold_end", 3'b111, 1'b0, 2'd0);
        to_edge(43); check_out("rel0",     3'b110, 1'b0, 2'd0);
        to_edge(46); check_out("rel0_hold", 3'b110, 1'b0, 2'd0);
        to_edge(47); check_out("rel1",     3'b100, 1'b0, 2'd0);
        to_edge(50); check_out("rel1_hold", 3'b100, 1'b0, 2'd0);
        to_edge(51); check_out("rel2",     3'b000, 1'b1, 2'd0);

        // One-cycle lock drop in RUN
        to_edge(60); pll_locked_i = 1'b0;
        to_edge(61); pll_locked_i = 1'b1;
        to_edge(62); check_out("lock_pre",  3'b000, 1'b1, 2'd0);
        to_edge(63); check_out("lock_loss", 3'b111, 1'b0, 2'd2);
        to_edge(94); check_out("relock_hold", 3'b111, 1'b0, 2'd2);
        to_edge(95); check_out("relock_r0", 3'b110, 1'b0, 2'd2);
        to_edge(99); check_out("relock_r1", 3'b100, 1'b0, 2'd2);
        to_edge(102); check_out("relock_r1h", 3'b100, 1'b0, 2'd2);
        to_edge(103); check_out("relock_r2", 3'b000, 1'b1, 2'd2);

        // Armed button held for 20 cycles in RUN
        to_edge(105); key_i = 4'd1;
        to_edge(110); btn_i = 1'b1;
        to_edge(120); check_out("btn_pre", 3'b000, 1'b1, 2'd2);
        to_edge(121); check_out("btn_hit", 3'b111, 1'b0, 2'd3);
        to_edge(130); btn_i = 1'b0;
        to_edge(170); check_out("btn_hold", 3'b111, 1'b0, 2'd3);
        to_edge(171); check_out("btn_r0", 3'b110, 1'b0, 2'd3);
        to_edge(179); check_out("btn_r2", 3'b000, 1'b1, 2'd3);

        // Button with wrong key, then a short glitch with the right key
        to_edge(185); key_i = 4'd2;
        to_edge(190); btn_i = 1'b1;
        to_edge(205); check_out("wrongkey_a", 3'b000, 1'b1, 2'd3);
        to_edge(210); btn_i = 1'b0;
        to_edge(215); check_out("wrongkey_b", 3'b000, 1'b1, 2'd3);
        to_edge(225); key_i = 4'd1;
        to_edge(230); btn_i = 1'b1;
        to_edge(235); btn_i = 1'b0;
        to_edge(245); check_out("glitch", 3'b000, 1'b1, 2'd3);

        // External reset in the middle of RELEASE
        to_edge(250); pll_locked_i = 1'b0;
        to_edge(251); pll_locked_i = 1'b1;
        to_edge(253); check_out("rst_lockloss", 3'b111, 1'b0, 2'd2);
        to_edge(287); check_out("rst_pre", 3'b110, 1'b0, 2'd2);
        reset_i = 1'b1;
        to_edge(288); check_out("rst_hit", 3'b111, 1'b0, 2'd1);
        reset_i = 1'b0;
        to_edge(319); check_out("rst_hold", 3'b111, 1'b0, 2'd1);
        to_edge(320); check_out("rst_r0", 3'b110, 1'b0, 2'd1);
        to_edge(328); check_out("rst_r2", 3'b000, 1'b1, 2'd1);

        // External reset together with lock loss: EXT wins
        to_edge(335); pll_locked_i = 1'b0;
        to_edge(337); check_out("both_pre", 3'b000, 1'b1, 2'd1);
        reset_i = 1'b1;
        to_edge(338); check_out("both_hit", 3'b111, 1'b0, 2'd1);
        reset_i = 1'b0;
        to_edge(340); check_out("both_after", 3'b111, 1'b0, 2'd1);

        // Lock loss while in HOLD
        pll_locked_i = 1'b1;
        to_edge(350); pll_locked_i = 1'b0;
        to_edge(352); check_out("holdloss_pre", 3'b111, 1'b0, 2'd1);
        to_edge(353); check_out("holdloss", 3'b111, 1'b0, 2'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
